// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: host-side PS/2 device-to-host frame decoder.
// Filters the pin clock, deframes 11-bit frames, folds E0/F0 into flags.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_error,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;

  logic          filt;
  logic [FW-1:0] fcnt;
  logic          differ;
  logic          flip;
  logic          fall;
  logic          dat;

  logic [TW-1:0] tcnt;
  logic          tmo;

  logic [7:0]    sr;
  logic [2:0]    bitcnt;
  logic          par;
  logic          ext;
  logic          brk;

  logic          stop_fall;
  logic          good;
  logic          is_e0;
  logic          is_f0;
  logic          emit;
  logic          err;
  logic          set_ext;
  logic          set_brk;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // flip marks the FILTER_LEN-th consecutive disagreeing cycle
  assign differ = (clk_s2 != filt);
  assign flip   = differ && (fcnt == FW'(FILTER_LEN - 1));
  assign fall   = flip && filt;
  assign dat    = dat_s2;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (!differ) begin
      fcnt <= '0;
    end else if (flip) begin
      filt <= clk_s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // a coinciding fall takes priority over the timeout
  assign tmo = (state != IDLE) && !fall &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      tcnt <= '0;
    end else if (state == IDLE || fall || tmo) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (fall && !dat) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (fall && bitcnt == 3'd7) begin
          state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      state_n = IDLE;
    end
  end

  assign stop_fall = (state == STOP) && fall;
  assign good      = dat && (^{sr, par});
  assign is_e0     = (sr == 8'hE0);
  assign is_f0     = (sr == 8'hF0);

  always_comb begin
    emit    = 1'b0;
    err     = 1'b0;
    set_ext = 1'b0;
    set_brk = 1'b0;
    unique case (1'b1)
      tmo:                               err     = 1'b1;
      stop_fall && !good:                err     = 1'b1;
      stop_fall && good && is_e0:        set_ext = 1'b1;
      stop_fall && good && is_f0:        set_brk = 1'b1;
      stop_fall && good && !is_e0 && !is_f0:
                                         emit    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sr          <= '0;
      bitcnt      <= '0;
      par         <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      scan_valid  <= emit;
      frame_error <= err;
      if (state == IDLE && fall && !dat) begin
        sr     <= '0;
        bitcnt <= '0;
      end
      if (state == DATA && fall) begin
        sr     <= {dat, sr[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (state == PARITY && fall) begin
        par <= dat;
      end
      if (tmo) begin
        sr     <= '0;
        bitcnt <= '0;
      end
      if (emit) begin
        scan_code   <= sr;
        is_extended <= ext;
        is_break    <= brk;
      end
      if (emit || err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
      if (set_ext) begin
        ext <= 1'b1;
      end
      if (set_brk) begin
        brk <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: table-driven and randomized checks of the
// PS/2 frame receiver against a frame-level prefix/emission model.
module tb_ps2_frame_receiver;

  localparam int FL = 8;
  localparam int TO = 400;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_error;
  logic       busy;

  ps2_frame_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock      (clk),
    .Resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .is_break   (is_break),
    .is_extended(is_extended),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int err_t = 0;
  int t_pin = 0;
  bit busy_seen = 1'b0;

  logic [7:0] held_code = 8'h00;
  bit held_brk = 1'b0;
  bit held_ext = 1'b0;
  bit m_ext = 1'b0;
  bit m_brk = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_error) begin
      n_err++;
      err_t = cyc;
    end
    if (scan_valid && frame_error) n_both++;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp,
                            input bit bs, input int nbits);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ bp;
    bits[10]  = ~bs;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(H);
      ps2_clk = 1'b0;
      t_pin = cyc;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic frame_check(input string name, input logic [7:0] b,
                             input bit bp, input bit bs, input bit ev,
                             input logic [7:0] code, input bit brk,
                             input bit ext, input bit ee);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(b, bp, bs, 11);
    tick(2 * H);
    chk({name, "/valid_cnt"}, n_valid - v0, int'(ev));
    chk({name, "/err_cnt"}, n_err - e0, int'(ee));
    if (ev) begin
      held_code = code;
      held_brk  = brk;
      held_ext  = ext;
    end
    chk({name, "/scan_code"}, int'(scan_code), int'(held_code));
    chk({name, "/is_break"}, int'(is_break), int'(held_brk));
    chk({name, "/is_extended"}, int'(is_extended), int'(held_ext));
    chk({name, "/busy"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    bit         ev;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    bit         ee;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int v0;
    int e0;
    logic [7:0] rb;
    bit rbp;
    bit rbs;
    bit rev;
    bit ree;
    logic [7:0] rcode;
    bit rbrk;
    bit rext;

    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{8'h6B, 1'b0, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b1, 1'b0};

    resetn  = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(3);
    chk("rst/scan_code", int'(scan_code), 0);
    chk("rst/scan_valid", int'(scan_valid), 0);
    chk("rst/is_break", int'(is_break), 0);
    chk("rst/is_extended", int'(is_extended), 0);
    chk("rst/frame_error", int'(frame_error), 0);
    chk("rst/busy", int'(busy), 0);
    resetn = 1'b1;
    tick(5);

    for (int i = 0; i < 14; i++) begin
      frame_check($sformatf("tbl%0d", i), tbl[i].b, tbl[i].bp,
                  tbl[i].bs, tbl[i].ev, tbl[i].code, tbl[i].brk,
                  tbl[i].ext, tbl[i].ee);
    end

    // timeout mid-frame, with a pending break prefix that must clear
    frame_check("tmo_pre", 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00,
                1'b0, 1'b0, 1'b0);
    e0 = n_err;
    send_frame(8'h29, 1'b0, 1'b0, 4);
    tick(H);
    chk("tmo/busy_mid", int'(busy), 1);
    tick(TO + FL + 20);
    chk("tmo/err_cnt", n_err - e0, 1);
    chk_rng("tmo/latency", err_t - t_pin, TO + FL, TO + FL + 4);
    chk("tmo/busy_after", int'(busy), 0);
    frame_check("tmo_post", 8'h29, 1'b0, 1'b0, 1'b1, 8'h29,
                1'b0, 1'b0, 1'b0);

    // short clock-low glitches and a long low with data high
    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    tick(FL - 1);
    ps2_clk = 1'b1;
    tick(5);
    ps2_dat = 1'b1;
    tick(30);
    chk("glitch/busy_seen", int'(busy_seen), 0);
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    tick(3 * FL);
    ps2_clk = 1'b1;
    tick(30);
    chk("idle_dat1/busy_seen", int'(busy_seen), 0);
    chk("glitch/valid_cnt", n_valid - v0, 0);
    chk("glitch/err_cnt", n_err - e0, 0);

    // reset mid-frame with a pending extended prefix
    frame_check("rst_pre", 8'hE0, 1'b0, 1'b0, 1'b0, 8'h00,
                1'b0, 1'b0, 1'b0);
    e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0, 6);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("mrst/scan_code", int'(scan_code), 0);
    chk("mrst/is_break", int'(is_break), 0);
    chk("mrst/is_extended", int'(is_extended), 0);
    chk("mrst/busy", int'(busy), 0);
    tick(TO + 50);
    chk("mrst/err_cnt", n_err - e0, 0);
    held_code = 8'h00;
    held_brk  = 1'b0;
    held_ext  = 1'b0;
    frame_check("mrst_post", 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C,
                1'b0, 1'b0, 1'b0);

    // randomized frames against the prefix-folding model
    m_ext = 1'b0;
    m_brk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rb = 8'hE0;
        2, 3:    rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rbp = 1'b0;
      rbs = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) rbp = 1'b1;
        else rbs = 1'b1;
      end
      rev   = 1'b0;
      ree   = 1'b0;
      rcode = 8'h00;
      rbrk  = 1'b0;
      rext  = 1'b0;
      if (rbp || rbs) begin
        ree   = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (rb == 8'hE0) begin
        m_ext = 1'b1;
      end else if (rb == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        rev   = 1'b1;
        rcode = rb;
        rbrk  = m_brk;
        rext  = m_ext;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      frame_check($sformatf("rnd%0d_%02h", i, rb), rb, rbp, rbs,
                  rev, rcode, rbrk, rext, ree);
    end

    chk("overlap_valid_err", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
